// File: rtl/mips_defs_pkg.sv
// Shared MIPS opcode/funct constants and multiply/divide unit types.
// Decode and execute import these so both sides agree on the encoding.
package mips_defs_pkg;

    localparam int unsigned WIDTH_DEF = 32;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_SRA   = 6'b000011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_ADDU  = 6'b100001;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SUBU  = 6'b100011;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;

    typedef enum logic {MdIdle = 1'b0, MdBusy = 1'b1} md_state_e;

    // funct[1:0] of mult/multu/div/divu maps directly onto this encoding
    typedef enum logic [1:0] {MdMult = 2'b00, MdMultu = 2'b01, MdDiv = 2'b10, MdDivu = 2'b11} md_op_e;

    function automatic logic is_hilo_funct(input logic [5:0] funct);
        return (funct inside {F_MFHI, F_MTHI, F_MFLO, F_MTLO, F_MULT, F_MULTU, F_DIV, F_DIVU});
    endfunction

endpackage

// File: rtl/ex_muldiv.sv
// Iterative multiply/divide unit owning HI/LO: one shift-add or restoring
// subtract step per cycle on operand magnitudes, sign fix-up on the last step.
module ex_muldiv
    import mips_defs_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_wr_hi,
    input  logic             i_wr_lo,
    input  logic [WIDTH-1:0] i_wdata,
    output logic             o_busy,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;

    md_state_e              r_state;
    md_state_e              w_state_d;
    logic [CntW-1:0]        r_cnt;
    logic                   r_is_div;
    logic                   r_neg_q;
    logic                   r_neg_r;
    logic [WIDTH-1:0]       r_div;
    logic [2*WIDTH-1:0]     r_acc;
    logic [WIDTH-1:0]       r_hi;
    logic [WIDTH-1:0]       r_lo;

    logic                   w_signed;
    logic                   w_a_neg;
    logic                   w_b_neg;
    logic [WIDTH-1:0]       w_a_mag;
    logic [WIDTH-1:0]       w_b_mag;
    logic                   w_last;
    logic [WIDTH:0]         w_sum;
    logic [WIDTH:0]         w_diff;
    logic [2*WIDTH-1:0]     w_acc_nx;
    logic [2*WIDTH-1:0]     w_prod;
    logic [WIDTH-1:0]       w_quo;
    logic [WIDTH-1:0]       w_rem;
    logic [WIDTH-1:0]       w_hi_fin;
    logic [WIDTH-1:0]       w_lo_fin;

    assign w_signed = ~i_op[0];
    assign w_a_neg  = w_signed & i_a[WIDTH-1];
    assign w_b_neg  = w_signed & i_b[WIDTH-1];
    assign w_a_mag  = w_a_neg ? -i_a : i_a;
    assign w_b_mag  = w_b_neg ? -i_b : i_b;
    assign w_last   = (r_state == MdBusy) && (r_cnt == CntW'(WIDTH - 1));

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
    always_comb begin
        w_sum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_div} : '0);
        w_diff   = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_div};
        w_acc_nx = {w_sum, r_acc[WIDTH-1:1]};
        if (r_is_div) begin
            if (!w_diff[WIDTH]) begin
                w_acc_nx = {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
            end else begin
                w_acc_nx = {r_acc[2*WIDTH-2:0], 1'b0};
            end
        end
    end

    always_comb begin
        w_prod   = r_neg_q ? -w_acc_nx : w_acc_nx;
        w_quo    = w_acc_nx[WIDTH-1:0];
        w_rem    = w_acc_nx[2*WIDTH-1:WIDTH];
        w_hi_fin = w_prod[2*WIDTH-1:WIDTH];
        w_lo_fin = w_prod[WIDTH-1:0];
        if (r_is_div) begin
            w_hi_fin = r_neg_r ? -w_rem : w_rem;
            w_lo_fin = r_neg_q ? -w_quo : w_quo;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            MdIdle:  if (i_start) w_state_d = MdBusy;
            MdBusy:  if (w_last) w_state_d = MdIdle;
            default: w_state_d = MdIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= MdIdle;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div    <= '0;
            r_acc    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_state <= w_state_d;
            if (r_state == MdIdle) begin
                if (i_start) begin
                    r_cnt    <= '0;
                    r_is_div <= i_op[1];
                    r_neg_q  <= w_a_neg ^ w_b_neg;
                    r_neg_r  <= w_a_neg;
                    r_div    <= w_b_mag;
                    r_acc    <= {{WIDTH{1'b0}}, w_a_mag};
                end
                if (i_wr_hi) r_hi <= i_wdata;
                if (i_wr_lo) r_lo <= i_wdata;
            end else begin
                r_acc <= w_acc_nx;
                r_cnt <= r_cnt + CntW'(1);
                if (w_last) begin
                    r_hi <= w_hi_fin;
                    r_lo <= w_lo_fin;
                end
            end
        end
    end

    assign o_busy = (r_state == MdBusy);
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: combinational ALU, shifter and branch compare, plus the
// HI/LO multiply/divide unit and the interlock that stalls HI/LO users.
module ex_stage
    import mips_defs_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [31:0]      Ins,
    input  logic [WIDTH-1:0] Rdata1,
    input  logic [WIDTH-1:0] Rdata2,
    input  logic [WIDTH-1:0] Ed32,
    output logic [WIDTH-1:0] Result,
    output logic             BrTaken,
    output logic             Stall
);

    logic [5:0]       w_op;
    logic [5:0]       w_funct;
    logic [4:0]       w_shamt;
    logic             w_rtype;
    logic             w_muldiv;
    logic             w_busy;
    logic             w_start;
    logic             w_wr_hi;
    logic             w_wr_lo;
    logic [WIDTH-1:0] w_hi;
    logic [WIDTH-1:0] w_lo;
    logic             w_unused;

    assign w_op     = Ins[31:26];
    assign w_funct  = Ins[5:0];
    assign w_shamt  = Ins[10:6];
    assign w_unused = ^Ins[25:11];
    assign w_rtype  = (w_op == OP_RTYPE);
    assign w_muldiv = w_rtype && (w_funct inside {F_MULT, F_MULTU, F_DIV, F_DIVU});

    assign Stall   = w_busy && w_rtype && is_hilo_funct(w_funct);
    assign w_start = w_muldiv && !Stall;
    assign w_wr_hi = w_rtype && (w_funct == F_MTHI) && !Stall;
    assign w_wr_lo = w_rtype && (w_funct == F_MTLO) && !Stall;

    ex_muldiv #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_start (w_start),
        .i_op    (w_funct[1:0]),
        .i_a     (Rdata1),
        .i_b     (Rdata2),
        .i_wr_hi (w_wr_hi),
        .i_wr_lo (w_wr_lo),
        .i_wdata (Rdata1),
        .o_busy  (w_busy),
        .o_hi    (w_hi),
        .o_lo    (w_lo)
    );

    always_comb begin
        Result = '0;
        if (w_rtype) begin
            case (w_funct)
                F_ADD, F_ADDU: Result = Rdata1 + Rdata2;
                F_SUB, F_SUBU: Result = Rdata1 - Rdata2;
                F_AND:         Result = Rdata1 & Rdata2;
                F_OR:          Result = Rdata1 | Rdata2;
                F_XOR:         Result = Rdata1 ^ Rdata2;
                F_NOR:         Result = ~(Rdata1 | Rdata2);
                F_SLT:         Result = {{(WIDTH-1){1'b0}}, $signed(Rdata1) < $signed(Rdata2)};
                F_SLTU:        Result = {{(WIDTH-1){1'b0}}, Rdata1 < Rdata2};
                F_SLL:         Result = Rdata2 << w_shamt;
                F_SRL:         Result = Rdata2 >> w_shamt;
                F_SRA:         Result = $signed(Rdata2) >>> w_shamt;
                F_MFHI:        Result = w_hi;
                F_MFLO:        Result = w_lo;
                default:       Result = '0;
            endcase
        end else begin
            case (w_op)
                OP_ADDI, OP_ADDIU, OP_LW, OP_SW: Result = Rdata1 + Ed32;
                OP_SLTI:  Result = {{(WIDTH-1){1'b0}}, $signed(Rdata1) < $signed(Ed32)};
                OP_SLTIU: Result = {{(WIDTH-1){1'b0}}, Rdata1 < Ed32};
                OP_ANDI:  Result = Rdata1 & Ed32;
                OP_ORI:   Result = Rdata1 | Ed32;
                OP_XORI:  Result = Rdata1 ^ Ed32;
                OP_LUI:   Result = Ed32 << 16;
                default:  Result = '0;
            endcase
        end
    end

    always_comb begin
        BrTaken = 1'b0;
        if (w_op == OP_BEQ) BrTaken = (Rdata1 == Rdata2);
        if (w_op == OP_BNE) BrTaken = (Rdata1 != Rdata2);
    end

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: stimulus pushes expected outputs into a queue from a
// cycle-level reference model; a negedge monitor pops and compares.
module tb_ex_stage;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] Ins = '0;
    logic [31:0] Rdata1 = '0;
    logic [31:0] Rdata2 = '0;
    logic [31:0] Ed32 = '0;
    logic [31:0] Result;
    logic        BrTaken;
    logic        Stall;

    ex_stage #(
        .WIDTH (32)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .Ins     (Ins),
        .Rdata1  (Rdata1),
        .Rdata2  (Rdata2),
        .Ed32    (Ed32),
        .Result  (Result),
        .BrTaken (BrTaken),
        .Stall   (Stall)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] res;
        logic        br;
        logic        st;
        string       name;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;

    // Reference state: architectural HI/LO plus cycles left until the pending result lands
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [31:0] p_hi = '0;
    logic [31:0] p_lo = '0;
    int          m_left = 0;

    logic [31:0] ops [35] = '{
        32'h20, 32'h21, 32'h22, 32'h23, 32'h24, 32'h25, 32'h26, 32'h27, 32'h2A, 32'h2B,
        32'h00, 32'h02, 32'h03, 32'h10, 32'h12, 32'h11, 32'h13, 32'h18, 32'h19, 32'h1A,
        32'h1B, 32'h08,
        32'h2000_0000, 32'h2400_0000, 32'h2800_0000, 32'h2C00_0000, 32'h3000_0000,
        32'h3400_0000, 32'h3800_0000, 32'h3C00_0000, 32'h8C00_0000, 32'hAC00_0000,
        32'h1000_0000, 32'h1400_0000, 32'h0800_0000
    };

    function automatic logic [31:0] rins(input logic [5:0] fn, input logic [4:0] sh);
        return {6'd0, 15'd0, sh, fn};
    endfunction

    function automatic logic [31:0] iins(input logic [5:0] op);
        return {op, 26'd0};
    endfunction

    function automatic logic is_hilo(input logic [31:0] ins);
        return (ins[31:26] == 6'd0) && (ins[5:0] inside {6'd16, 6'd17, 6'd18, 6'd19,
                                                          6'd24, 6'd25, 6'd26, 6'd27});
    endfunction

    function automatic logic [31:0] ref_result(input logic [31:0] ins, a, b, imm);
        logic signed [31:0] sb;
        logic [4:0]         sh;
        sb = b;
        sh = ins[10:6];
        if (ins[31:26] == 6'd0) begin
            case (ins[5:0])
                6'd32, 6'd33: return a + b;
                6'd34, 6'd35: return a - b;
                6'd36: return a & b;
                6'd37: return a | b;
                6'd38: return a ^ b;
                6'd39: return ~(a | b);
                6'd42: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                6'd43: return (a < b) ? 32'd1 : 32'd0;
                6'd0:  return b << sh;
                6'd2:  return b >> sh;
                6'd3:  return sb >>> sh;
                6'd16: return m_hi;
                6'd18: return m_lo;
                default: return 32'd0;
            endcase
        end
        case (ins[31:26])
            6'd8, 6'd9, 6'd35, 6'd43: return a + imm;
            6'd10: return ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
            6'd11: return (a < imm) ? 32'd1 : 32'd0;
            6'd12: return a & imm;
            6'd13: return a | imm;
            6'd14: return a ^ imm;
            6'd15: return {imm[15:0], 16'h0000};
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic ref_br(input logic [31:0] ins, a, b);
        if (ins[31:26] == 6'd4) return a == b;
        if (ins[31:26] == 6'd5) return a != b;
        return 1'b0;
    endfunction

    // Advance the model across the clock edge that ends the current cycle
    task automatic model_edge(input logic [31:0] ins, a, b, input logic rst);
        longint      sa, sb, sp;
        logic [63:0] ua, ub, up;
        if (rst) begin
            m_hi = '0; m_lo = '0; m_left = 0;
            return;
        end
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
        end else if (ins[31:26] == 6'd0) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            ua = {32'd0, a};
            ub = {32'd0, b};
            case (ins[5:0])
                6'd17: m_hi = a;
                6'd19: m_lo = a;
                6'd24: begin sp = sa * sb; {p_hi, p_lo} = sp; m_left = 32; end
                6'd25: begin up = ua * ub; {p_hi, p_lo} = up; m_left = 32; end
                6'd26: begin
                    if (b == 0) begin
                        p_lo = a[31] ? 32'd1 : 32'hFFFF_FFFF;
                        p_hi = a;
                    end else begin
                        p_lo = 32'(sa / sb);
                        p_hi = 32'(sa % sb);
                    end
                    m_left = 32;
                end
                6'd27: begin
                    if (b == 0) begin
                        p_lo = 32'hFFFF_FFFF;
                        p_hi = a;
                    end else begin
                        p_lo = a / b;
                        p_hi = a % b;
                    end
                    m_left = 32;
                end
                default: ;
            endcase
        end
    endtask

    task automatic step(input logic [31:0] ins, a, b, imm, input logic rst, input bit use_c,
                        input logic [31:0] cres, input logic cbr, cst, input string nm);
        exp_t e;
        @(posedge CLK);
        #1;
        Ins = ins; Rdata1 = a; Rdata2 = b; Ed32 = imm; RST = rst;
        if (use_c) begin
            e.res = cres; e.br = cbr; e.st = cst;
        end else begin
            e.res = ref_result(ins, a, b, imm);
            e.br  = ref_br(ins, a, b);
            e.st  = (m_left > 0) && is_hilo(ins);
        end
        e.name = nm;
        q.push_back(e);
        model_edge(ins, a, b, rst);
    endtask

    task automatic stepm(input logic [31:0] ins, a, b, imm, input string nm);
        step(ins, a, b, imm, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, nm);
    endtask

    task automatic stepc(input logic [31:0] ins, a, b, imm, input logic [31:0] res,
                         input logic br, st, input string nm);
        step(ins, a, b, imm, 1'b0, 1'b1, res, br, st, nm);
    endtask

    always @(negedge CLK) begin
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            checks++;
            if (Result !== mon_e.res) begin
                failures++;
                $display("FAIL %s Result: got %h expected %h", mon_e.name, Result, mon_e.res);
            end
            checks++;
            if (BrTaken !== mon_e.br) begin
                failures++;
                $display("FAIL %s BrTaken: got %b expected %b", mon_e.name, BrTaken, mon_e.br);
            end
            checks++;
            if (Stall !== mon_e.st) begin
                failures++;
                $display("FAIL %s Stall: got %b expected %b", mon_e.name, Stall, mon_e.st);
            end
        end
    end

    initial begin
        step(32'd0, 0, 0, 0, 1'b1, 1'b1, 32'd0, 1'b0, 1'b0, "reset");
        step(32'd0, 0, 0, 0, 1'b1, 1'b1, 32'd0, 1'b0, 1'b0, "reset");
        stepc(rins(6'd16, 0), 0, 0, 0, 32'd0, 1'b0, 1'b0, "reset_hi");
        stepc(rins(6'd32, 0), 32'd7, 32'hFFFF_FFFD, 0, 32'd4, 1'b0, 1'b0, "add");
        stepc(rins(6'd43, 0), 32'd1, 32'hFFFF_FFFF, 0, 32'd1, 1'b0, 1'b0, "sltu");
        stepc(rins(6'd42, 0), 32'd1, 32'hFFFF_FFFF, 0, 32'd0, 1'b0, 1'b0, "slt");
        stepc(rins(6'd3, 5'd4), 0, 32'h8000_0000, 0, 32'hF800_0000, 1'b0, 1'b0, "sra");
        stepc(iins(6'd15), 0, 0, 32'h1234, 32'h1234_0000, 1'b0, 1'b0, "lui");
        stepc(iins(6'd4), 32'd5, 32'd5, 0, 32'd0, 1'b1, 1'b0, "beq");
        stepc(iins(6'd5), 32'd5, 32'd5, 0, 32'd0, 1'b0, 1'b0, "bne");
        stepc(rins(6'd32, 0), 32'd5, 32'd5, 0, 32'd10, 1'b0, 1'b0, "add_br");

        stepc(rins(6'd24, 0), 32'hFFFF_FFFF, 32'd2, 0, 32'd0, 1'b0, 1'b0, "mult_issue");
        for (int i = 0; i < 32; i++)
            stepc(rins(6'd18, 0), 0, 0, 0, 32'd0, 1'b0, 1'b1, "mflo_stall");
        stepc(rins(6'd18, 0), 0, 0, 0, 32'hFFFF_FFFE, 1'b0, 1'b0, "mult_lo");
        stepc(rins(6'd16, 0), 0, 0, 0, 32'hFFFF_FFFF, 1'b0, 1'b0, "mult_hi");

        stepc(rins(6'd25, 0), 32'hFFFF_FFFF, 32'd2, 0, 32'd0, 1'b0, 1'b0, "multu_issue");
        for (int i = 0; i < 32; i++)
            stepc(rins(6'd32, 0), 32'd7, 32'hFFFF_FFFD, 0, 32'd4, 1'b0, 1'b0, "add_busy");
        stepc(rins(6'd16, 0), 0, 0, 0, 32'd1, 1'b0, 1'b0, "multu_hi");
        stepc(rins(6'd18, 0), 0, 0, 0, 32'hFFFF_FFFE, 1'b0, 1'b0, "multu_lo");

        stepc(rins(6'd26, 0), 32'hFFFF_FFF9, 32'd2, 0, 32'd0, 1'b0, 1'b0, "div_issue");
        for (int i = 0; i < 32; i++)
            stepc(rins(6'd18, 0), 0, 0, 0, 32'hFFFF_FFFE, 1'b0, 1'b1, "div_stall");
        stepc(rins(6'd18, 0), 0, 0, 0, 32'hFFFF_FFFD, 1'b0, 1'b0, "div_lo");
        stepc(rins(6'd16, 0), 0, 0, 0, 32'hFFFF_FFFF, 1'b0, 1'b0, "div_hi");

        stepc(rins(6'd27, 0), 32'd7, 32'd0, 0, 32'd0, 1'b0, 1'b0, "divu0_issue");
        for (int i = 0; i < 32; i++)
            stepc(rins(6'd16, 0), 0, 0, 0, 32'hFFFF_FFFF, 1'b0, 1'b1, "divu0_stall");
        stepc(rins(6'd16, 0), 0, 0, 0, 32'd7, 1'b0, 1'b0, "divu0_hi");
        stepc(rins(6'd18, 0), 0, 0, 0, 32'hFFFF_FFFF, 1'b0, 1'b0, "divu0_lo");

        stepc(rins(6'd24, 0), 32'd3, 32'd4, 0, 32'd0, 1'b0, 1'b0, "mult1_issue");
        for (int i = 0; i < 32; i++)
            stepc(rins(6'd24, 0), 32'd5, 32'd6, 0, 32'd0, 1'b0, 1'b1, "mult2_stall");
        stepc(rins(6'd24, 0), 32'd5, 32'd6, 0, 32'd0, 1'b0, 1'b0, "mult2_issue");
        for (int i = 0; i < 32; i++)
            stepc(rins(6'd18, 0), 0, 0, 0, 32'd12, 1'b0, 1'b1, "mflo2_stall");
        stepc(rins(6'd18, 0), 0, 0, 0, 32'd30, 1'b0, 1'b0, "mult2_lo");
        stepc(rins(6'd16, 0), 0, 0, 0, 32'd0, 1'b0, 1'b0, "mult2_hi");

        stepc(rins(6'd24, 0), 32'hFFFF_FFFF, 32'd2, 0, 32'd0, 1'b0, 1'b0, "abort_issue");
        for (int i = 0; i < 9; i++)
            stepc(rins(6'd33, 0), 32'd1, 32'd2, 0, 32'd3, 1'b0, 1'b0, "abort_add");
        step(rins(6'd33, 0), 32'd1, 32'd2, 0, 1'b1, 1'b1, 32'd3, 1'b0, 1'b0, "abort_rst");
        stepc(rins(6'd16, 0), 0, 0, 0, 32'd0, 1'b0, 1'b0, "abort_hi");
        stepc(rins(6'd18, 0), 0, 0, 0, 32'd0, 1'b0, 1'b0, "abort_lo");

        for (int i = 0; i < 1500; i++) begin
            int          k;
            logic [31:0] ins, a, b, imm;
            logic        rst;
            k   = $urandom_range(0, 34);
            ins = ops[k];
            if (ins[31:26] == 6'd0) ins = ins | ($urandom & 32'h03FF_FFC0);
            else ins = ins | ($urandom & 32'h03FF_FFFF);
            a   = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 20)) - 32'd10;
            b   = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 20)) - 32'd10;
            if ($urandom_range(0, 3) == 0) b = a;
            imm = $urandom;
            rst = ($urandom_range(0, 299) == 0);
            step(ins, a, b, imm, rst, 1'b0, 32'd0, 1'b0, 1'b0, "random");
        end

        repeat (3) @(negedge CLK);
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
